// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with water level, almost flags, std/FWFT read,
// sync flush, sticky overflow/underflow.
// Ports:
//   clk, rst_n (async low), clr (sync flush)
//   wr_en/wr_data -> wr_full, almost_full
//   rd_en -> rd_data, rd_valid, rd_empty, almost_empty
//   water_level, overflow, underflow
module sync_fifo_wl #(
  parameter int DATA_WIDTH       = 10,
  parameter int DEPTH_WIDTH      = 10,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] CAP =
    (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_LVL =
    (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LVL =
    (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0] level;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 full, empty;
  logic                 wr_acc, rd_acc;
  logic [DEPTH_WIDTH-1:0] rd_addr;

  // Pointer MSB distinguishes full from empty on wrap.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == CAP);
  assign empty   = (level == '0);
  assign rd_addr = rd_ptr_q[DEPTH_WIDTH-1:0];

  assign water_level  = level;
  assign wr_full      = full;
  assign rd_empty     = empty;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      // Flush wins; same-cycle requests vanish silently.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      wr_acc = wr_en & ~full;
      rd_acc = rd_en & ~empty;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem_q[rd_addr];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (rd_acc) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Bench for sync_fifo_wl: standard-mode scoreboard plus FWFT directed
// checks on a second instance.
module tb_sync_fifo_wl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       s_clr = 0, s_we = 0, s_re = 0;
  logic [9:0] s_wd = '0;
  logic       s_full, s_af, s_rv, s_empty, s_ae, s_ov, s_un;
  logic [9:0] s_rd;
  logic [4:0] s_lvl;

  logic       f_clr = 0, f_we = 0, f_re = 0;
  logic [9:0] f_wd = '0;
  logic       f_full, f_af, f_rv, f_empty, f_ae, f_ov, f_un;
  logic [9:0] f_rd;
  logic [4:0] f_lvl;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_fifo_wl #(
    .DATA_WIDTH(10), .DEPTH_WIDTH(4), .FWFT(0),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(s_clr),
    .wr_en(s_we), .wr_data(s_wd), .wr_full(s_full),
    .almost_full(s_af), .rd_en(s_re), .rd_data(s_rd),
    .rd_valid(s_rv), .rd_empty(s_empty),
    .almost_empty(s_ae), .water_level(s_lvl),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_wl #(
    .DATA_WIDTH(10), .DEPTH_WIDTH(4), .FWFT(1),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(f_clr),
    .wr_en(f_we), .wr_data(f_wd), .wr_full(f_full),
    .almost_full(f_af), .rd_en(f_re), .rd_data(f_rd),
    .rd_valid(f_rv), .rd_empty(f_empty),
    .almost_empty(f_ae), .water_level(f_lvl),
    .overflow(f_ov), .underflow(f_un)
  );

  typedef struct {
    logic [9:0] d;
    int         c;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] model[$];
  logic       m_ov = 0, m_un = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Monitor: pops expected reads whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_rv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexp: got %0h want none", s_rd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", int'(s_rd), int'(e.d));
          chk("rd_lat", cyc, e.c);
        end
      end else if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL rd_missing: got none want %0h",
                 exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of standard-mode stimulus plus flag checks.
  task automatic step(input logic we, input logic [9:0] wd,
                      input logic re, input logic cl);
    logic rd_ok, wr_ok, fu, em;
    int   lvl;
    s_we  = we;
    s_wd  = wd;
    s_re  = re;
    s_clr = cl;
    rd_ok = 1'b0;
    if (cl) begin
      model.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      fu = (model.size() == 16);
      em = (model.size() == 0);
      rd_ok = re && !em;
      wr_ok = we && !fu;
      if (rd_ok) exp_q.push_back('{model.pop_front(), cyc + 1});
      if (wr_ok) model.push_back(wd);
      if (we && fu) m_ov = 1'b1;
      if (re && em) m_un = 1'b1;
    end
    @(posedge clk);
    #1;
    s_we  = 0;
    s_re  = 0;
    s_clr = 0;
    lvl = model.size();
    chk("level", int'(s_lvl), lvl);
    chk("full", int'(s_full), int'(lvl == 16));
    chk("empty", int'(s_empty), int'(lvl == 0));
    chk("afull", int'(s_af), int'(lvl >= 14));
    chk("aempty", int'(s_ae), int'(lvl <= 2));
    chk("ovf", int'(s_ov), int'(m_ov));
    chk("unf", int'(s_un), int'(m_un));
    chk("rd_valid", int'(s_rv), int'(rd_ok));
  endtask

  task automatic chk_reset();
    chk("rst_lvl", int'(s_lvl), 0);
    chk("rst_empty", int'(s_empty), 1);
    chk("rst_full", int'(s_full), 0);
    chk("rst_ae", int'(s_ae), 1);
    chk("rst_af", int'(s_af), 0);
    chk("rst_rv", int'(s_rv), 0);
    chk("rst_rd", int'(s_rd), 0);
    chk("rst_ov", int'(s_ov), 0);
    chk("rst_un", int'(s_un), 0);
    chk("rst_f_rv", int'(f_rv), 0);
  endtask

  initial begin
    #2;
    chk_reset();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 0x3FF..0x3F0
    for (int i = 0; i < 16; i++) step(1, 10'h3FF - 10'(i), 0, 0);
    chk("fill_full", int'(s_full), 1);
    chk("fill_lvl", int'(s_lvl), 16);

    // Overflow while full
    step(1, 10'h123, 0, 0);
    chk("ovf_set", int'(s_ov), 1);
    chk("ovf_lvl", int'(s_lvl), 16);

    // Drain in order
    for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    chk("drain_empty", int'(s_empty), 1);
    step(0, '0, 0, 1);

    // Level 8 then 40 cycles of simultaneous traffic
    for (int i = 0; i < 8; i++) step(1, 10'h050 + 10'(i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 10'h100 + 10'(i), 1, 0);
    chk("sim_lvl", int'(s_lvl), 8);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // Underflow on empty
    step(0, '0, 1, 0);
    chk("unf_set", int'(s_un), 1);
    chk("unf_rv", int'(s_rv), 0);
    step(0, '0, 0, 1);
    step(1, 10'h0AA, 1, 0);
    chk("wr_rd_empty_lvl", int'(s_lvl), 1);
    chk("wr_rd_empty_unf", int'(s_un), 1);

    // Flush at level 9 with requests
    for (int i = 0; i < 8; i++) step(1, 10'h200 + 10'(i), 0, 0);
    chk("pre_clr_lvl", int'(s_lvl), 9);
    step(1, 10'h3AB, 1, 1);
    chk("clr_lvl", int'(s_lvl), 0);
    chk("clr_empty", int'(s_empty), 1);
    chk("clr_unf", int'(s_un), 0);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) step(1, 10'h010 + 10'(i), 0, 0);
    step(1, 10'h020, 1, 0);
    s_we = 1;
    s_re = 1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset();
    exp_q.delete();
    model.delete();
    m_ov = 0;
    m_un = 0;
    s_we = 0;
    s_re = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, '0, 0, 0);

    // FWFT instance
    f_we = 1;
    f_wd = 10'h2AA;
    @(posedge clk);
    #1;
    f_wd = 10'h155;
    chk("fwft_rv1", int'(f_rv), 1);
    chk("fwft_d1", int'(f_rd), 10'h2AA);
    @(posedge clk);
    #1;
    f_we = 0;
    chk("fwft_lvl2", int'(f_lvl), 2);
    chk("fwft_d1b", int'(f_rd), 10'h2AA);
    f_re = 1;
    @(posedge clk);
    #1;
    chk("fwft_rv2", int'(f_rv), 1);
    chk("fwft_d2", int'(f_rd), 10'h155);
    @(posedge clk);
    #1;
    f_re = 0;
    chk("fwft_rv3", int'(f_rv), 0);
    chk("fwft_empty", int'(f_empty), 1);
    chk("fwft_unf", int'(f_un), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
